// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing generator:
//   - counter width used for column/row positions
//   - default 640x480@60 timing constants (pixels for horizontal, lines for
//     vertical)
//   - segment encoding used by the generic axis FSM, plus the horizontal and
//     vertical state enums that alias it one-for-one
//   - axis_total(): length of one axis period from its four segment lengths
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_VIDEO_WIDTH       = 3;
    localparam int DEF_ACTIVE_COLS       = 640;
    localparam int DEF_FRONT_PORCH_HORIZ = 16;
    localparam int DEF_SYNC_PULSE_HORIZ  = 96;
    localparam int DEF_BACK_PORCH_HORIZ  = 48;
    localparam int DEF_ACTIVE_ROWS       = 480;
    localparam int DEF_FRONT_PORCH_VERT  = 10;
    localparam int DEF_SYNC_PULSE_VERT   = 2;
    localparam int DEF_BACK_PORCH_VERT   = 33;

    // Generic segment of one axis. The horizontal and vertical enums below use
    // the same numeric encoding so the axis FSM output can be cast directly.
    typedef enum logic [1:0] {
        SEG_ACTIVE = 2'd0,
        SEG_FRONT  = 2'd1,
        SEG_SYNC   = 2'd2,
        SEG_BACK   = 2'd3
    } seg_t;

    typedef enum logic [1:0] {
        H_ACTIVE = 2'd0,
        H_FRONT  = 2'd1,
        H_SYNC   = 2'd2,
        H_BACK   = 2'd3
    } h_state_t;

    typedef enum logic [1:0] {
        V_ACTIVE = 2'd0,
        V_FRONT  = 2'd1,
        V_SYNC   = 2'd2,
        V_BACK   = 2'd3
    } v_state_t;

    function automatic int axis_total(input int active, input int front,
                                      input int sync, input int back);
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// -----------------------------------------------------------------------------
// vga_axis_fsm
// One timing axis (horizontal or vertical): position counter, wrap detection
// and the ACTIVE/FRONT/SYNC/BACK segment FSM. The counter and the FSM advance
// together, so seg_o always describes count_o.
//
// Ports
//   clk_i    in   pixel clock
//   rst_n_i  in   asynchronous active-low reset (count 0, SEG_ACTIVE)
//   en_i     in   global pixel enable
//   carry_i  in   advance request from the faster axis (tie high for columns)
//   count_o  out  current position, 0..TOTAL-1
//   seg_o    out  segment containing count_o
//   carry_o  out  carry_i while count_o is the last position (wrap pending)
//
// Parameters are the four segment lengths; FRONT and BACK may be 0 (segment
// skipped), ACTIVE and SYNC must be at least 1.
// -----------------------------------------------------------------------------
module vga_axis_fsm
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_ACTIVE_COLS,
    parameter int FRONT  = DEF_FRONT_PORCH_HORIZ,
    parameter int SYNC   = DEF_SYNC_PULSE_HORIZ,
    parameter int BACK   = DEF_BACK_PORCH_HORIZ
)(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             carry_i,
    output logic [CNT_W-1:0] count_o,
    output seg_t             seg_o,
    output logic             carry_o
);

    localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

    localparam logic [CNT_W-1:0] LAST_POS    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(ACTIVE + FRONT);
    localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(ACTIVE + FRONT + SYNC);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    seg_t             seg_q;
    seg_t             seg_next;
    logic             at_last;
    logic             step;

    assign step       = en_i & carry_i;
    assign at_last    = (count_q == LAST_POS);
    assign count_next = at_last ? '0 : count_q + CNT_W'(1);

    // State register (counter travels with it).
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            seg_q   <= SEG_ACTIVE;
        end else if (step) begin
            count_q <= count_next;
            seg_q   <= seg_next;
        end
    end

    // Next-state: the segment is chosen by the position being entered, so a
    // zero-length porch falls straight through to the following segment.
    // NOTE: the default at the top of the block keeps every path assigned and
    // prevents a latch from being inferred.
    always_comb begin
        seg_next = seg_q;
        if (at_last) begin
            seg_next = SEG_ACTIVE;
        end else begin
            unique case (seg_q)
                SEG_ACTIVE: if (count_next == FRONT_START)
                                seg_next = (FRONT > 0) ? SEG_FRONT : SEG_SYNC;
                SEG_FRONT:  if (count_next == SYNC_START)
                                seg_next = SEG_SYNC;
                SEG_SYNC:   if (count_next == BACK_START)
                                seg_next = SEG_BACK;
                SEG_BACK:   seg_next = SEG_BACK;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        count_o = count_q;
        seg_o   = seg_q;
        carry_o = carry_i & at_last;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator with video gating.
//   Stage 0: column/row counters and their segment FSMs (two vga_axis_fsm).
//   Stage 1: one register stage producing syncs, active flag, frame-start
//            pulse and gated video, all aligned to each other.
// TOTAL_COLS/TOTAL_ROWS are the sums of the four segment lengths per axis and
// are derived inside each axis instance.
//
// Ports
//   clk_i                       in   pixel clock
//   rst_n_i                     in   asynchronous active-low reset
//   en_i                        in   advance one pixel per clock while high
//   red/grn/blu_video_i         in   pixel for the current stage-0 position
//   col_count_o, row_count_o    out  stage-0 position
//   Hsync_o, Vsync_o            out  active-low sync pulses (stage 1)
//   active_o                    out  visible pixel on video outputs (stage 1)
//   frame_start_o               out  first pixel of a frame (stage 1, gated by en_i)
//   red/grn/blu_video_o         out  video, zero outside the visible area
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int VIDEO_WIDTH       = DEF_VIDEO_WIDTH,
    parameter int ACTIVE_COLS       = DEF_ACTIVE_COLS,
    parameter int FRONT_PORCH_HORIZ = DEF_FRONT_PORCH_HORIZ,
    parameter int SYNC_PULSE_HORIZ  = DEF_SYNC_PULSE_HORIZ,
    parameter int BACK_PORCH_HORIZ  = DEF_BACK_PORCH_HORIZ,
    parameter int ACTIVE_ROWS       = DEF_ACTIVE_ROWS,
    parameter int FRONT_PORCH_VERT  = DEF_FRONT_PORCH_VERT,
    parameter int SYNC_PULSE_VERT   = DEF_SYNC_PULSE_VERT,
    parameter int BACK_PORCH_VERT   = DEF_BACK_PORCH_VERT
)(
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   en_i,
    input  logic [VIDEO_WIDTH-1:0] red_video_i,
    input  logic [VIDEO_WIDTH-1:0] grn_video_i,
    input  logic [VIDEO_WIDTH-1:0] blu_video_i,
    output logic [CNT_W-1:0]       col_count_o,
    output logic [CNT_W-1:0]       row_count_o,
    output logic                   Hsync_o,
    output logic                   Vsync_o,
    output logic                   active_o,
    output logic                   frame_start_o,
    output logic [VIDEO_WIDTH-1:0] red_video_o,
    output logic [VIDEO_WIDTH-1:0] grn_video_o,
    output logic [VIDEO_WIDTH-1:0] blu_video_o
);

    seg_t     h_seg;
    seg_t     v_seg;
    h_state_t h_state;
    v_state_t v_state;
    logic     h_carry;
    logic     v_carry;
    logic     pix_active;

    // Columns advance on every enabled clock.
    vga_axis_fsm #(
        .ACTIVE (ACTIVE_COLS),
        .FRONT  (FRONT_PORCH_HORIZ),
        .SYNC   (SYNC_PULSE_HORIZ),
        .BACK   (BACK_PORCH_HORIZ)
    ) u_h_axis (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (en_i),
        .carry_i (1'b1),
        .count_o (col_count_o),
        .seg_o   (h_seg),
        .carry_o (h_carry)
    );

    // Rows advance only on the edge where the column wraps, so both counters
    // wrap together at the end of the frame.
    vga_axis_fsm #(
        .ACTIVE (ACTIVE_ROWS),
        .FRONT  (FRONT_PORCH_VERT),
        .SYNC   (SYNC_PULSE_VERT),
        .BACK   (BACK_PORCH_VERT)
    ) u_v_axis (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (en_i),
        .carry_i (h_carry),
        .count_o (row_count_o),
        .seg_o   (v_seg),
        .carry_o (v_carry)
    );

    assign h_state    = h_state_t'(h_seg);
    assign v_state    = v_state_t'(v_seg);
    assign pix_active = (h_state == H_ACTIVE) && (v_state == V_ACTIVE);

    // origin_q marks stage-0 position (0,0). It is set by reset (counters are
    // cleared) and by the enabled edge on which both axes wrap, which avoids a
    // pair of wide zero comparators.
    logic origin_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            origin_q <= 1'b1;
        end else if (en_i) begin
            origin_q <= v_carry;
        end
    end

    // Stage 1: everything here describes the stage-0 position of the
    // previous enabled clock, and holds while en_i is low.
    logic                   hsync_q;
    logic                   vsync_q;
    logic                   active_q;
    logic                   frame_first_q;
    logic [VIDEO_WIDTH-1:0] red_q;
    logic [VIDEO_WIDTH-1:0] grn_q;
    logic [VIDEO_WIDTH-1:0] blu_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            active_q      <= 1'b0;
            frame_first_q <= 1'b0;
            red_q         <= '0;
            grn_q         <= '0;
            blu_q         <= '0;
        end else if (en_i) begin
            hsync_q       <= (h_state != H_SYNC);
            vsync_q       <= (v_state != V_SYNC);
            active_q      <= pix_active;
            frame_first_q <= origin_q;
            red_q         <= pix_active ? red_video_i : '0;
            grn_q         <= pix_active ? grn_video_i : '0;
            blu_q         <= pix_active ? blu_video_i : '0;
        end
    end

    assign Hsync_o       = hsync_q;
    assign Vsync_o       = vsync_q;
    assign active_o      = active_q;
    // The held stage-1 flag must not repeat the pulse during a pause.
    assign frame_start_o = frame_first_q & en_i;
    assign red_video_o   = red_q;
    assign grn_video_o   = grn_q;
    assign blu_video_o   = blu_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Three instances share clock, reset, enable and video inputs:
//   dut 0: default 640x480 timing (horizontal behaviour, pause at col 639)
//   dut 1: 16/2/3/4 x 10/1/2/3 (25x16, whole frames in a few hundred clocks)
//   dut 2: 4/0/1/1 on both axes (6x6, zero-width front porch)
// The reference model tracks each instance as a linear pixel index within the
// frame and derives column, row, sync, visibility and video from plain
// arithmetic on that index.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int N = 3;

    logic       clk_i   = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       en_i    = 1'b0;
    logic [2:0] red_in  = '0;
    logic [2:0] grn_in  = '0;
    logic [2:0] blu_in  = '0;

    logic [9:0] col [N];
    logic [9:0] row [N];
    logic       hs  [N];
    logic       vs  [N];
    logic       act [N];
    logic       fs  [N];
    logic [2:0] ro  [N];
    logic [2:0] go  [N];
    logic [2:0] bo  [N];

    always #5 clk_i = ~clk_i;

    vga_timing_gen u_dut0 (
        .clk_i (clk_i), .rst_n_i (rst_n_i), .en_i (en_i),
        .red_video_i (red_in), .grn_video_i (grn_in), .blu_video_i (blu_in),
        .col_count_o (col[0]), .row_count_o (row[0]),
        .Hsync_o (hs[0]), .Vsync_o (vs[0]), .active_o (act[0]),
        .frame_start_o (fs[0]),
        .red_video_o (ro[0]), .grn_video_o (go[0]), .blu_video_o (bo[0])
    );

    vga_timing_gen #(
        .ACTIVE_COLS (16), .FRONT_PORCH_HORIZ (2), .SYNC_PULSE_HORIZ (3), .BACK_PORCH_HORIZ (4),
        .ACTIVE_ROWS (10), .FRONT_PORCH_VERT (1),  .SYNC_PULSE_VERT (2),  .BACK_PORCH_VERT (3)
    ) u_dut1 (
        .clk_i (clk_i), .rst_n_i (rst_n_i), .en_i (en_i),
        .red_video_i (red_in), .grn_video_i (grn_in), .blu_video_i (blu_in),
        .col_count_o (col[1]), .row_count_o (row[1]),
        .Hsync_o (hs[1]), .Vsync_o (vs[1]), .active_o (act[1]),
        .frame_start_o (fs[1]),
        .red_video_o (ro[1]), .grn_video_o (go[1]), .blu_video_o (bo[1])
    );

    vga_timing_gen #(
        .ACTIVE_COLS (4), .FRONT_PORCH_HORIZ (0), .SYNC_PULSE_HORIZ (1), .BACK_PORCH_HORIZ (1),
        .ACTIVE_ROWS (4), .FRONT_PORCH_VERT (0),  .SYNC_PULSE_VERT (1),  .BACK_PORCH_VERT (1)
    ) u_dut2 (
        .clk_i (clk_i), .rst_n_i (rst_n_i), .en_i (en_i),
        .red_video_i (red_in), .grn_video_i (grn_in), .blu_video_i (blu_in),
        .col_count_o (col[2]), .row_count_o (row[2]),
        .Hsync_o (hs[2]), .Vsync_o (vs[2]), .active_o (act[2]),
        .frame_start_o (fs[2]),
        .red_video_o (ro[2]), .grn_video_o (go[2]), .blu_video_o (bo[2])
    );

    // Observed outputs packed as {col,row,hsync,vsync,active,frame_start,r,g,b}.
    logic [32:0] obs [N];
    for (genvar g = 0; g < N; g++) begin : g_obs
        assign obs[g] = {col[g], row[g], hs[g], vs[g], act[g], fs[g], ro[g], go[g], bo[g]};
    end

    localparam logic [32:0] RST_PACK = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0};

    // Timing of each instance.
    int h_a [N] = '{640, 16, 4};
    int h_f [N] = '{16,  2,  0};
    int h_s [N] = '{96,  3,  1};
    int h_b [N] = '{48,  4,  1};
    int v_a [N] = '{480, 10, 4};
    int v_f [N] = '{10,  1,  0};
    int v_s [N] = '{2,   2,  1};
    int v_b [N] = '{33,  3,  1};

    int total = 0;
    int bad   = 0;

    // ---------------------------------------------------------------- model
    function automatic int cols_tot(input int i);
        return h_a[i] + h_f[i] + h_s[i] + h_b[i];
    endfunction

    function automatic int frame_len(input int i);
        return cols_tot(i) * (v_a[i] + v_f[i] + v_s[i] + v_b[i]);
    endfunction

    function automatic logic in_hsync(input int i, input int p);
        int c;
        c = p % cols_tot(i);
        return (c >= h_a[i] + h_f[i]) && (c < h_a[i] + h_f[i] + h_s[i]);
    endfunction

    function automatic logic in_vsync(input int i, input int p);
        int r;
        r = p / cols_tot(i);
        return (r >= v_a[i] + v_f[i]) && (r < v_a[i] + v_f[i] + v_s[i]);
    endfunction

    function automatic logic visible(input int i, input int p);
        return ((p % cols_tot(i)) < h_a[i]) && ((p / cols_tot(i)) < v_a[i]);
    endfunction

    int         pos   [N];
    logic       m_h   [N];
    logic       m_v   [N];
    logic       m_act [N];
    logic       m_fsq [N];
    logic [2:0] m_r   [N];
    logic [2:0] m_g   [N];
    logic [2:0] m_b   [N];

    always @(posedge clk_i or negedge rst_n_i) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n_i) begin
                pos[i]   <= 0;
                m_h[i]   <= 1'b1;
                m_v[i]   <= 1'b1;
                m_act[i] <= 1'b0;
                m_fsq[i] <= 1'b0;
                m_r[i]   <= '0;
                m_g[i]   <= '0;
                m_b[i]   <= '0;
            end else if (en_i) begin
                m_h[i]   <= !in_hsync(i, pos[i]);
                m_v[i]   <= !in_vsync(i, pos[i]);
                m_act[i] <= visible(i, pos[i]);
                m_fsq[i] <= (pos[i] == 0);
                m_r[i]   <= visible(i, pos[i]) ? red_in : 3'd0;
                m_g[i]   <= visible(i, pos[i]) ? grn_in : 3'd0;
                m_b[i]   <= visible(i, pos[i]) ? blu_in : 3'd0;
                pos[i]   <= (pos[i] + 1) % frame_len(i);
            end
        end
    end

    function automatic logic [32:0] exp_pack(input int i);
        return {10'(pos[i] % cols_tot(i)), 10'(pos[i] / cols_tot(i)),
                m_h[i], m_v[i], m_act[i], m_fsq[i] & en_i, m_r[i], m_g[i], m_b[i]};
    endfunction

    // ---------------------------------------------------------------- stimulus
    task automatic apply_reset();
        @(negedge clk_i);
        rst_n_i = 1'b0;
        en_i    = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic randomize_video();
        red_in = 3'($urandom_range(0, 7));
        grn_in = 3'($urandom_range(0, 7));
        blu_in = 3'($urandom_range(0, 7));
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_n_i = 1'b0;
        en_i    = 1'b1;
        randomize_video();
        repeat (3) @(negedge clk_i);
        for (int i = 0; i < N; i++) begin
            total++;
            if (obs[i] !== RST_PACK) begin
                bad++;
                $display("FAIL reset_values dut%0d got=%h want=%h", i, obs[i], RST_PACK);
            end
        end
        rst_n_i = 1'b1;
        en_i    = 1'b0;
    endtask

    task automatic test_hsync_default();
        int fall_at;
        int low_line0;
        int low_line1;
        fall_at   = -1;
        low_line0 = 0;
        low_line1 = 0;
        apply_reset();
        en_i = 1'b1;
        randomize_video();
        for (int k = 1; k <= 1600; k++) begin
            @(negedge clk_i);
            for (int i = 0; i < N; i++) begin
                total++;
                if (obs[i] !== exp_pack(i)) begin
                    bad++;
                    if (bad <= 20)
                        $display("FAIL hsync_run dut%0d k=%0d got=%h want=%h", i, k, obs[i], exp_pack(i));
                end
            end
            if (!hs[0] && fall_at < 0) fall_at = k;
            if (!hs[0] && k <= 800) low_line0++;
            if (!hs[0] && k > 800)  low_line1++;
            randomize_video();
        end
        total++;
        if (fall_at !== 657) begin
            bad++;
            $display("FAIL hsync_first_fall got=%0d want=657", fall_at);
        end
        total++;
        if (low_line0 !== 96) begin
            bad++;
            $display("FAIL hsync_width_line0 got=%0d want=96", low_line0);
        end
        total++;
        if (low_line1 !== 96) begin
            bad++;
            $display("FAIL hsync_width_line1 got=%0d want=96", low_line1);
        end
    endtask

    task automatic test_frame_medium();
        int vs_low;
        int act_cnt;
        int fs_cnt;
        int vid7;
        int stray;
        int vs_first;
        vs_low   = 0;
        act_cnt  = 0;
        fs_cnt   = 0;
        vid7     = 0;
        stray    = 0;
        vs_first = -1;
        apply_reset();
        en_i   = 1'b1;
        red_in = 3'd7;
        grn_in = 3'd7;
        blu_in = 3'd7;
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk_i);
            for (int i = 0; i < N; i++) begin
                total++;
                if (obs[i] !== exp_pack(i)) begin
                    bad++;
                    if (bad <= 20)
                        $display("FAIL frame_run dut%0d k=%0d got=%h want=%h", i, k, obs[i], exp_pack(i));
                end
            end
            if (!vs[1]) vs_low++;
            if (!vs[1] && vs_first < 0) vs_first = k;
            if (act[1]) act_cnt++;
            if (fs[1]) fs_cnt++;
            if (ro[1] == 3'd7 && go[1] == 3'd7 && bo[1] == 3'd7) vid7++;
            if (!act[1] && (ro[1] != 0 || go[1] != 0 || bo[1] != 0)) stray++;
        end
        total++;
        if (vs_low !== 100) begin bad++; $display("FAIL vsync_width got=%0d want=100", vs_low); end
        total++;
        if (vs_first !== 276) begin bad++; $display("FAIL vsync_first_fall got=%0d want=276", vs_first); end
        total++;
        if (act_cnt !== 320) begin bad++; $display("FAIL active_count got=%0d want=320", act_cnt); end
        total++;
        if (fs_cnt !== 2) begin bad++; $display("FAIL frame_start_count got=%0d want=2", fs_cnt); end
        total++;
        if (vid7 !== 320 || stray !== 0) begin
            bad++;
            $display("FAIL video_gating got=%0d/%0d want=320/0", vid7, stray);
        end
    endtask

    task automatic test_pause();
        apply_reset();
        en_i = 1'b1;
        randomize_video();
        for (int k = 1; k <= 639; k++) begin
            @(negedge clk_i);
            for (int i = 0; i < N; i++) begin
                total++;
                if (obs[i] !== exp_pack(i)) begin
                    bad++;
                    if (bad <= 20)
                        $display("FAIL pause_lead dut%0d k=%0d got=%h want=%h", i, k, obs[i], exp_pack(i));
                end
            end
            randomize_video();
        end
        total++;
        if (col[0] !== 10'd639) begin bad++; $display("FAIL pause_entry_col got=%0d want=639", col[0]); end
        en_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_i);
            for (int i = 0; i < N; i++) begin
                total++;
                if (obs[i] !== exp_pack(i) || fs[i] !== 1'b0) begin
                    bad++;
                    if (bad <= 20)
                        $display("FAIL pause_hold dut%0d k=%0d got=%h want=%h", i, k, obs[i], exp_pack(i));
                end
            end
            randomize_video();
        end
        en_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (col[0] !== 10'd640 || act[0] !== 1'b1) begin
            bad++;
            $display("FAIL pause_resume got=col%0d/act%0b want=col640/act1", col[0], act[0]);
        end
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk_i);
            for (int i = 0; i < N; i++) begin
                total++;
                if (obs[i] !== exp_pack(i)) begin
                    bad++;
                    if (bad <= 20)
                        $display("FAIL pause_tail dut%0d k=%0d got=%h want=%h", i, k, obs[i], exp_pack(i));
                end
            end
            randomize_video();
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        en_i = 1'b1;
        randomize_video();
        for (int k = 1; k <= 5 * 25 + 7; k++) begin
            @(negedge clk_i);
            for (int i = 0; i < N; i++) begin
                total++;
                if (obs[i] !== exp_pack(i)) begin
                    bad++;
                    if (bad <= 20)
                        $display("FAIL areset_lead dut%0d k=%0d got=%h want=%h", i, k, obs[i], exp_pack(i));
                end
            end
            randomize_video();
        end
        total++;
        if (col[1] !== 10'd7 || row[1] !== 10'd5) begin
            bad++;
            $display("FAIL areset_position got=%0d,%0d want=7,5", col[1], row[1]);
        end
        #2 rst_n_i = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            total++;
            if (obs[i] !== RST_PACK) begin
                bad++;
                $display("FAIL areset_no_clock dut%0d got=%h want=%h", i, obs[i], RST_PACK);
            end
        end
        #1 rst_n_i = 1'b1;
        @(negedge clk_i);
        for (int i = 0; i < N; i++) begin
            total++;
            if (fs[i] !== 1'b1 || obs[i] !== exp_pack(i)) begin
                bad++;
                $display("FAIL areset_frame_start dut%0d got=%h want=%h", i, obs[i], exp_pack(i));
            end
        end
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk_i);
            for (int i = 0; i < N; i++) begin
                total++;
                if (obs[i] !== exp_pack(i)) begin
                    bad++;
                    if (bad <= 20)
                        $display("FAIL areset_tail dut%0d k=%0d got=%h want=%h", i, k, obs[i], exp_pack(i));
                end
            end
            randomize_video();
        end
    endtask

    task automatic test_small();
        int lows;
        lows = 0;
        apply_reset();
        en_i = 1'b1;
        randomize_video();
        for (int k = 1; k <= 72; k++) begin
            @(negedge clk_i);
            total++;
            if (hs[2] !== !(((k - 1) % 6) == 4)) begin
                bad++;
                $display("FAIL small_hsync k=%0d got=%0b want=%0b", k, hs[2], !(((k - 1) % 6) == 4));
            end
            total++;
            if (obs[2] !== exp_pack(2)) begin
                bad++;
                $display("FAIL small_run k=%0d got=%h want=%h", k, obs[2], exp_pack(2));
            end
            if (!hs[2]) lows++;
            randomize_video();
        end
        total++;
        if (lows !== 12) begin bad++; $display("FAIL small_hsync_count got=%0d want=12", lows); end
    endtask

    task automatic test_random_enable();
        apply_reset();
        for (int k = 1; k <= 3000; k++) begin
            en_i = ($urandom_range(0, 9) < 7);
            randomize_video();
            @(negedge clk_i);
            for (int i = 0; i < N; i++) begin
                total++;
                if (obs[i] !== exp_pack(i)) begin
                    bad++;
                    if (bad <= 20)
                        $display("FAIL random_en dut%0d k=%0d got=%h want=%h", i, k, obs[i], exp_pack(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_hsync_default();
        test_frame_medium();
        test_pause();
        test_async_reset();
        test_small();
        test_random_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter VIDEO_WIDTH, default 3, bits per colour channel.
REQ-002 Parameter ACTIVE_COLS, default 640, visible pixels per line.
REQ-003 Parameter FRONT_PORCH_HORIZ, default 16, pixels between active video and Hsync pulse.
REQ-004 Parameter SYNC_PULSE_HORIZ, default 96, Hsync pulse width in pixels.
REQ-005 Parameter BACK_PORCH_HORIZ, default 48, pixels between Hsync pulse and next line.
REQ-006 Parameters ACTIVE_ROWS 480, FRONT_PORCH_VERT 10, SYNC_PULSE_VERT 2 and BACK_PORCH_VERT 33 are the vertical equivalents, in lines.
REQ-007 TOTAL_COLS = sum of the four horizontal parameters (default 800); TOTAL_ROWS = sum of the four vertical parameters (default 525); both derived, never set directly.
REQ-008 clk_i  input  1  pixel clock; the only clock.
REQ-009 rst_n_i  input  1  asynchronous active-low reset.
REQ-010 en_i  input  1  advance timing by one pixel when high.
REQ-011 red_video_i, grn_video_i, blu_video_i  input  VIDEO_WIDTH each  pixel for the position on col_count_o/row_count_o.
REQ-012 col_count_o  output  10  current column, 0..TOTAL_COLS-1.
REQ-013 row_count_o  output  10  current row, 0..TOTAL_ROWS-1.
REQ-014 Hsync_o, Vsync_o  output  1 each  active-low sync pulses.
REQ-015 active_o  output  1  high while a visible pixel is presented on the video outputs.
REQ-016 frame_start_o  output  1  single-cycle pulse with the first pixel of each frame.
REQ-017 red_video_o, grn_video_o, blu_video_o  output  VIDEO_WIDTH each  gated video.

Function
REQ-018 Column counter increments on each clock with en_i high; wraps TOTAL_COLS-1 -> 0.
REQ-019 Row counter increments only when the column wraps; wraps TOTAL_ROWS-1 -> 0 on the same edge the column wraps.
REQ-020 Horizontal FSM states H_ACTIVE, H_FRONT, H_SYNC, H_BACK; entry at col 0, ACTIVE_COLS, ACTIVE_COLS+FRONT_PORCH_HORIZ and ACTIVE_COLS+FRONT_PORCH_HORIZ+SYNC_PULSE_HORIZ respectively; H_BACK -> H_ACTIVE at wrap.
REQ-021 Vertical FSM V_ACTIVE, V_FRONT, V_SYNC, V_BACK with identical boundaries in rows; transitions occur only on a column wrap.
REQ-022 Stage 0: col_count_o and row_count_o are the counter registers themselves.
REQ-023 Stage 1, registered one clock after stage 0: Hsync_o low iff stage-0 state was H_SYNC; Vsync_o low iff V_SYNC; active_o high iff H_ACTIVE and V_ACTIVE.
REQ-024 Stage 1 video outputs equal the sampled inputs when stage-0 position was active, otherwise 0.
REQ-025 Syncs, active_o, frame_start_o and video outputs are mutually aligned; latency from count to these outputs is exactly 1 clock.
REQ-026 frame_start_o high for one stage-1 cycle corresponding to col 0, row 0.
REQ-027 en_i low: counters, FSMs and all stage-1 registers hold their values; frame_start_o is forced 0 while en_i is low.
REQ-028 A zero-width porch parameter skips that state; SYNC_PULSE parameters are at least 1.

Reset
REQ-029 rst_n_i low asynchronously forces counters to 0, FSMs to H_ACTIVE/V_ACTIVE, Hsync_o=Vsync_o=1, active_o=0, frame_start_o=0 and video outputs 0.
REQ-030 Reset asserted mid-frame abandons the frame; after release, the first enabled edge produces stage-1 output for col 0, row 0 with frame_start_o=1.

Structure
REQ-031 Horizontal/vertical state encodings and default timing constants belong in shared package vga_pkg.
REQ-032 One sub-module vga_axis_fsm, instantiated twice (horizontal and vertical), holds counter, wrap and state decode for one axis and is parameterised by the four segment lengths.

Verification
REQ-033 Reset, en_i=1, defaults -> Hsync_o low for exactly 96 clocks per 800, first falling edge at col 656 + 1 clock.
REQ-034 Full frame -> Vsync_o low for exactly 2 lines (1600 clocks) starting at row 490; frame period 420000 clocks; frame_start_o once per frame.
REQ-035 Inputs held at 7/7/7 -> video outputs 7 for 640x480 active clocks per frame, 0 elsewhere; active_o count 307200.
REQ-036 en_i low for 20 clocks at col 639 -> all outputs frozen, then resume at col 640 with no lost or duplicated pixel.
REQ-037 rst_n_i pulsed asynchronously at row 300, col 100 -> outputs reach reset values without a clock edge; next frame_start_o one enabled clock after release.
REQ-038 Small parameters (ACTIVE 4/FP 0/SYNC 1/BP 1 both axes) -> TOTAL 6x6, H_FRONT skipped, Hsync_o low at col 4 only.
